// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor/direction types for the elevator cluster
package elevator_pkg;

    localparam int N_FLOORS_DEFAULT   = 4;
    localparam int FLOOR_BITS_DEFAULT = 2;

    typedef logic [FLOOR_BITS_DEFAULT-1:0] floor_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, debounce counter and rising-edge detect for one raw button
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            if (s2 != stable) begin
                if (cnt == CNT_MAX) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // High for the single cycle after stable rises; the top registers it.
    assign press_pulse = stable & ~stable_d;

endmodule

// File: rtl/call_panel.sv
// rtl/call_panel.sv - button conditioning, request pulses and call lamps; CALL_PANEL_DUP_SUPPRESS_EN drops presses on lit lamps
module call_panel
    import elevator_pkg::*;
#(
    parameter int N_FLOORS        = N_FLOORS_DEFAULT,
    parameter int FLOOR_BITS      = FLOOR_BITS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_FLOORS-1:0]   btn_inside,
    input  logic [N_FLOORS-1:0]   btn_up,
    input  logic [N_FLOORS-1:0]   btn_down,
    input  logic [FLOOR_BITS-1:0] current_floor,
    input  logic                  door_open,
    input  logic                  direction,
    output logic [N_FLOORS-1:0]   inside_req,
    output logic [N_FLOORS-1:0]   up_call,
    output logic [N_FLOORS-1:0]   down_call,
    output logic [N_FLOORS-1:0]   lamp_inside,
    output logic [N_FLOORS-1:0]   lamp_up,
    output logic [N_FLOORS-1:0]   lamp_down
);

    // No hall-up call from the top floor, no hall-down call from the ground floor.
    localparam logic [N_FLOORS-1:0] UP_MASK   = {1'b0, {(N_FLOORS-1){1'b1}}};
    localparam logic [N_FLOORS-1:0] DOWN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

    logic [N_FLOORS-1:0] rise_inside, rise_up, rise_down;
    logic [N_FLOORS-1:0] acc_inside, acc_up, acc_down;
    logic [N_FLOORS-1:0] clr_inside, clr_up, clr_down;
    logic [N_FLOORS-1:0] fire_inside, fire_up, fire_down;
    dir_t                dir;

    assign dir = dir_t'(direction);

    for (genvar i = 0; i < N_FLOORS; i++) begin : g_btn
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inside (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (btn_inside[i]),
            .press_pulse (rise_inside[i])
        );
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (btn_up[i]),
            .press_pulse (rise_up[i])
        );
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
            .clk         (clk),
            .rst_n       (rst_n),
            .raw         (btn_down[i]),
            .press_pulse (rise_down[i])
        );
    end

    assign acc_inside = rise_inside;
    assign acc_up     = rise_up & UP_MASK;
    assign acc_down   = rise_down & DOWN_MASK;

    // Terminal floors serve their only hall direction regardless of travel direction.
    always_comb begin
        clr_inside = '0;
        clr_up     = '0;
        clr_down   = '0;
        for (int f = 0; f < N_FLOORS; f++) begin
            if (door_open && (current_floor == FLOOR_BITS'(f))) begin
                clr_inside[f] = 1'b1;
                clr_up[f]     = (dir == DIR_UP) || (f == 0);
                clr_down[f]   = (dir == DIR_DOWN) || (f == N_FLOORS - 1);
            end
        end
    end

`ifdef CALL_PANEL_DUP_SUPPRESS_EN
    assign fire_inside = acc_inside & ~clr_inside & ~lamp_inside;
    assign fire_up     = acc_up & ~clr_up & ~lamp_up;
    assign fire_down   = acc_down & ~clr_down & ~lamp_down;
`else
    assign fire_inside = acc_inside & ~clr_inside;
    assign fire_up     = acc_up & ~clr_up;
    assign fire_down   = acc_down & ~clr_down;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inside_req  <= '0;
            up_call     <= '0;
            down_call   <= '0;
            lamp_inside <= '0;
            lamp_up     <= '0;
            lamp_down   <= '0;
        end else begin
            inside_req  <= fire_inside;
            up_call     <= fire_up;
            down_call   <= fire_down;
            lamp_inside <= (lamp_inside | acc_inside) & ~clr_inside;
            lamp_up     <= (lamp_up | acc_up) & ~clr_up;
            lamp_down   <= (lamp_down | acc_down) & ~clr_down;
        end
    end

endmodule

// File: tb/tb_call_panel.sv
// tb/tb_call_panel.sv - self-checking bench for call_panel
module tb_call_panel;

    localparam int NF = 4;
    localparam int D  = 8;
    localparam logic [11:0] MASK = 12'b1110_0111_1111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] btn_inside = '0, btn_up = '0, btn_down = '0;
    logic [1:0]    current_floor = '0;
    logic          door_open = 1'b0;
    logic          direction = 1'b0;
    logic [NF-1:0] inside_req, up_call, down_call;
    logic [NF-1:0] lamp_inside, lamp_up, lamp_down;

    int n_cmp = 0;
    int n_bad = 0;

    call_panel #(.N_FLOORS(NF), .FLOOR_BITS(2), .DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_inside    (btn_inside),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .current_floor (current_floor),
        .door_open     (door_open),
        .direction     (direction),
        .inside_req    (inside_req),
        .up_call       (up_call),
        .down_call     (down_call),
        .lamp_inside   (lamp_inside),
        .lamp_up       (lamp_up),
        .lamp_down     (lamp_down)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: a level is accepted once the raw input was sampled different
    // from the accepted level on D consecutive edges; the press shows two
    // edges later (synchroniser) plus one registered edge.
    logic [11:0] hist [0:4095];
    logic [11:0] mst = '0, mrise = '0, mpulse = '0, mlamp = '0;
    int          e = 0;

    always @(posedge clk) begin
        logic [11:0] raw, clr, pend;
        if (!rst_n) begin
            hist[e % 4096] = '0;
            mst = '0; mrise = '0; mpulse = '0; mlamp = '0;
        end else begin
            raw = {btn_down, btn_up, btn_inside};
            hist[e % 4096] = raw;
            clr = '0;
            if (door_open) begin
                for (int f = 0; f < NF; f++) begin
                    if (int'(current_floor) == f) begin
                        clr[f]     = 1'b1;
                        clr[4 + f] = direction || (f == 0);
                        clr[8 + f] = !direction || (f == NF - 1);
                    end
                end
            end
            pend = mrise & MASK;
`ifdef CALL_PANEL_DUP_SUPPRESS_EN
            mpulse = pend & ~clr & ~mlamp;
`else
            mpulse = pend & ~clr;
`endif
            mlamp = (mlamp | pend) & ~clr;
            mrise = '0;
            if (e >= D + 1) begin
                for (int b = 0; b < 12; b++) begin
                    logic all_diff;
                    all_diff = 1'b1;
                    for (int j = 2; j <= D + 1; j++)
                        if (hist[(e - j) % 4096][b] == mst[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        mst[b]   = ~mst[b];
                        mrise[b] = mst[b];
                    end
                end
            end
        end
        e++;
    end

    always @(negedge rst_n) begin
        mst = '0; mrise = '0; mpulse = '0; mlamp = '0;
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("pulses", {20'd0, down_call, up_call, inside_req}, {20'd0, mpulse});
            check("lamps", {20'd0, lamp_down, lamp_up, lamp_inside}, {20'd0, mlamp});
        end
    end

    function automatic logic pulse_of(input int sel, input int bi);
        case (sel)
            0:       return inside_req[bi];
            1:       return up_call[bi];
            default: return down_call[bi];
        endcase
    endfunction

    task automatic set_btn(input int sel, input int bi, input logic v);
        case (sel)
            0:       btn_inside[bi] = v;
            1:       btn_up[bi]     = v;
            default: btn_down[bi]   = v;
        endcase
    endtask

    // Press one button for 'hold' cycles, watch its pulse for n cycles.
    task automatic run(input int sel, input int bi, input int hold, input int n,
                       output int cnt, output int first);
        cnt = 0; first = 0;
        set_btn(sel, bi, 1'b1);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (pulse_of(sel, bi)) begin
                cnt++;
                if (first == 0) first = k;
            end
            if (k == hold) set_btn(sel, bi, 1'b0);
        end
        set_btn(sel, bi, 1'b0);
    endtask

    task automatic serve(input int f, input logic dir);
        current_floor = 2'(f);
        direction     = dir;
        door_open     = 1'b1;
        @(negedge clk);
        door_open     = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt, first, c2, f2;
        int hold_len [3] = '{5, 7, 8};
        int hold_exp [3] = '{0, 0, 1};

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_outputs", {8'd0, inside_req, up_call, down_call, lamp_inside, lamp_up, lamp_down}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic press latency and lamp
        run(0, 2, 20, 25, cnt, first);
        check("inside2_pulse_count", cnt, 1);
        check("inside2_latency", first, 11);
        repeat (15) @(negedge clk);
        check("lamp_inside2_held", lamp_inside[2], 1'b1);

        // Glitch rejection: 5 and 7 cycles rejected, 8 accepted
        for (int i = 0; i < 3; i++) begin
            run(1, 1, hold_len[i], 25, cnt, first);
            check($sformatf("up1_hold%0d_pulses", hold_len[i]), cnt, hold_exp[i]);
            check($sformatf("up1_hold%0d_lamp", hold_len[i]), lamp_up[1], hold_exp[i][0]);
        end
        run(2, 1, 12, 25, cnt, first);
        check("down1_pulse_count", cnt, 1);

        // Directional service clear at floor 1
        serve(1, 1'b1);
        check("svc_up_clears_up", lamp_up[1], 1'b0);
        check("svc_up_keeps_down", lamp_down[1], 1'b1);
        check("svc_up_keeps_inside2", lamp_inside[2], 1'b1);
        serve(1, 1'b0);
        check("svc_down_clears_down", lamp_down[1], 1'b0);

        // Masked bits and top-floor down call
        run(1, 3, 20, 25, cnt, first);
        check("up3_masked_pulses", cnt, 0);
        check("up3_masked_lamp", lamp_up[3], 1'b0);
        run(2, 0, 20, 25, cnt, first);
        check("down0_masked_pulses", cnt, 0);
        check("down0_masked_lamp", lamp_down[0], 1'b0);
        run(2, 3, 20, 25, cnt, first);
        check("down3_pulse_count", cnt, 1);
        check("down3_lamp", lamp_down[3], 1'b1);

        // Two buttons pressed together pulse in the same cycle
        btn_inside[0] = 1'b1; btn_up[0] = 1'b1;
        first = 0; f2 = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (inside_req[0] && first == 0) first = k;
            if (up_call[0] && f2 == 0) f2 = k;
            if (k == 15) begin btn_inside[0] = 1'b0; btn_up[0] = 1'b0; end
        end
        check("simul_inside0_latency", first, 11);
        check("simul_up0_latency", f2, 11);

        // Press accepted in the same cycle the floor is served: clear wins
        serve(2, 1'b1);
        check("inside2_cleared", lamp_inside[2], 1'b0);
        btn_inside[2] = 1'b1; btn_up[2] = 1'b1;
        cnt = 0; c2 = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (inside_req[2]) cnt++;
            if (up_call[2]) c2++;
            if (k == 10) begin current_floor = 2'd2; direction = 1'b1; door_open = 1'b1; end
            if (k == 11) door_open = 1'b0;
            if (k == 20) begin btn_inside[2] = 1'b0; btn_up[2] = 1'b0; end
        end
        check("clash_inside2_pulses", cnt, 0);
        check("clash_up2_pulses", c2, 0);
        check("clash_lamps", {30'd0, lamp_inside[2], lamp_up[2]}, 32'd0);

        // Reset mid-debounce with lit lamps, button held through release
        check("pre_reset_lamp_down3", lamp_down[3], 1'b1);
        btn_inside[1] = 1'b1;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {8'd0, inside_req, up_call, down_call, lamp_inside, lamp_up, lamp_down}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (inside_req[1]) cnt++;
        end
        check("held_through_reset_pulses", cnt, 1);
        check("held_through_reset_lamp", lamp_inside[1], 1'b1);
        btn_inside[1] = 1'b0;
        repeat (15) @(negedge clk);

        // Second press of an already lit lamp
        run(0, 1, 15, 25, cnt, first);
`ifdef CALL_PANEL_DUP_SUPPRESS_EN
        check("dup_press_pulses", cnt, 0);
`else
        check("dup_press_pulses", cnt, 1);
`endif
        check("dup_press_lamp", lamp_inside[1], 1'b1);
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
